cpu6_bus_ctl: RTL

- Downstream bus stage of the CPU6 core.
- Consumes the CPU's `addressBus`, `dataOutBus` and `writeEnBus`, and returns `dataInBus`.
- Decodes the 16-bit address into three regions: on-chip RAM, an external boot ROM port, and the MUX0 serial port.
- MUX0 has a transmit FIFO, an 8N1 serializer and status/data registers, so console programs run unmodified in simulation and on iCE40.

---
 rtl/cpu6_bus_pkg.sv | 18 +
 rtl/mux_uart_tx.sv | 100 ++++++++++
 rtl/cpu6_bus_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu6_bus_pkg.sv
// Shared constants and state types for the CPU6 bus stage and its MUX0 serial port.
package cpu6_bus_pkg;

    localparam logic [15:0] DEF_ROM_BASE = 16'hFC00;
    localparam logic [15:0] DEF_MUX_BASE = 16'hF200;

    // MUX0 status register bit positions
    localparam int ST_RX_READY = 0;
    localparam int ST_TX_NFULL = 1;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_RX_FRAME = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_TX_BUSY  = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mux_uart_tx.sv
// MUX0 transmit path: byte FIFO feeding an 8N1 serializer with a registered line output.
module mux_uart_tx
    import cpu6_bus_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       overflow,
    output logic       uart_tx,
    output logic       tx_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_end, pop, accept;

    assign bit_end  = clk_cnt == CW'(CLKS_PER_BIT - 1);
    // Popping at the end of STOP chains frames with no idle gap.
    assign pop      = (count != '0) && ((state == TX_IDLE) || (state == TX_STOP && bit_end));
    assign full     = count == (PW+1)'(DEPTH);
    assign accept   = push && (!full || pop);
    assign overflow = push && !accept;
    assign tx_busy  = (state != TX_IDLE) || (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(accept) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= TX_IDLE;
            uart_tx <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
            case (state)
                TX_IDLE: begin
                    clk_cnt <= '0;
                    if (pop) begin
                        state   <= TX_START;
                        shift   <= mem[rd_ptr];
                        uart_tx <= 1'b0;
                    end
                end
                TX_START: if (bit_end) begin
                    state   <= TX_DATA;
                    bit_cnt <= '0;
                    uart_tx <= shift[0];
                end
                TX_DATA: if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state   <= TX_STOP;
                        uart_tx <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= shift >> 1;
                        uart_tx <= shift[1];
                    end
                end
                TX_STOP: if (bit_end) begin
                    if (pop) begin
                        state   <= TX_START;
                        shift   <= mem[rd_ptr];
                        uart_tx <= 1'b0;
                    end else begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu6_bus_ctl.sv
// CPU6 bus stage: address decode, on-chip RAM, boot ROM port and MUX0 serial port.
// Define MUX_RX_EN to build the MUX0 receiver; otherwise uart_rx is ignored.
module cpu6_bus_ctl
    import cpu6_bus_pkg::*;
#(
    parameter int          RAM_WORDS     = 4096,
    parameter logic [15:0] ROM_BASE      = DEF_ROM_BASE,
    parameter logic [15:0] MUX_BASE      = DEF_MUX_BASE,
    parameter int          TX_FIFO_DEPTH = 4,
    parameter int          CLKS_PER_BIT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic [7:0]  dataOutBus,
    input  logic        writeEnBus,
    output logic [7:0]  dataInBus,
    output logic [9:0]  rom_address,
    input  logic [7:0]  rom_data,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        tx_busy
);
    localparam int          AW       = $clog2(RAM_WORDS);
    localparam logic [15:0] MUX_DATA = MUX_BASE + 16'd1;

    logic [7:0] ram [RAM_WORDS];
    logic       in_ram, ack, push;
    logic       tx_full, tx_overflow, tx_ovf;
    logic [7:0] status;
    logic [7:0] rx_hold;
    logic       rx_ready, rx_ovr, rx_frame;

    assign in_ram      = {16'h0, addressBus} < 32'(RAM_WORDS);
    assign ack         = writeEnBus && (addressBus == MUX_BASE);
    assign push        = writeEnBus && (addressBus == MUX_DATA);
    assign rom_address = addressBus[9:0];

    always_ff @(posedge clock) begin
        if (writeEnBus && in_ram) ram[addressBus[AW-1:0]] <= dataOutBus;
    end

    mux_uart_tx #(.DEPTH(TX_FIFO_DEPTH), .CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (dataOutBus),
        .full      (tx_full),
        .overflow  (tx_overflow),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    // A drop in the same cycle as an acknowledge keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset)            tx_ovf <= 1'b0;
        else if (tx_overflow) tx_ovf <= 1'b1;
        else if (ack)         tx_ovf <= 1'b0;
    end

`ifdef MUX_RX_EN
    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_t     rx_state;
    logic [2:0]    rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_line;

    // rx_sync[1] is the synchronized line, rx_sync[2] its previous value.
    assign rx_line = rx_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_sync  <= '1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_hold  <= '0;
            rx_ready <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_frame <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[1:0], uart_rx};
            rx_cnt  <= rx_cnt + CW'(1);
            if (ack) begin
                rx_ready <= 1'b0;
                rx_ovr   <= 1'b0;
                rx_frame <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_sync[2] && !rx_line) rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_line ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_line, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_state <= RX_IDLE;
                    if (!rx_line) begin
                        rx_frame <= 1'b1;
                    end else begin
                        rx_hold  <= rx_shift;
                        rx_ready <= 1'b1;
                        if (rx_ready) rx_ovr <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
`else
    logic rx_unused;
    assign rx_unused = uart_rx;
    assign rx_hold   = 8'h00;
    assign rx_ready  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_frame  = 1'b0;
`endif

    always_comb begin
        status              = 8'h00;
        status[ST_RX_READY] = rx_ready;
        status[ST_TX_NFULL] = !tx_full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_FRAME] = rx_frame;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_TX_BUSY]  = tx_busy;
    end

    always_comb begin
        dataInBus = 8'hFF;
        if (in_ram)                        dataInBus = ram[addressBus[AW-1:0]];
        else if (addressBus >= ROM_BASE)   dataInBus = rom_data;
        else if (addressBus == MUX_BASE)   dataInBus = status;
        else if (addressBus == MUX_DATA)   dataInBus = rx_hold;
    end

endmodule
